ysyx_041461_clint: RTL and testbench

YSYX_041461_CLINT -- requirements
Module: ysyx_041461_CLINT

---
 rtl/ysyx_041461_clint.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_041461_clint.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_clint.sv
// ysyx_041461_clint -- core-local interruptor (msip / mtimecmp / mtime)
//
// Purpose:
//   Memory-mapped machine timer and software-interrupt block on the MEM-stage
//   request/response port. It holds one outstanding access and answers it
//   exactly one cycle after acceptance. mtime advances once every TICK_DIV
//   clk cycles, and the machine timer interrupt is a registered
//   (mtime >= mtimecmp) compare.
//
// Register map (byte addresses, 8-byte aligned, 64-bit accesses):
//   BASE + 0x0000  msip      bit 0 only
//   BASE + 0x4000  mtimecmp
//   BASE + 0xBFF8  mtime
//   Any other address, or addr[2:0] != 0, returns resp_err = 1 and
//   rdata = 0, and changes no state.
//
// Parameters:
//   BASE      base address of the block
//   TICK_DIV  clk cycles per mtime increment (1..65535)
//
// Configuration macro:
//   YSYX_041461_CLINT_MSIP_EN  when defined, msip is implemented and drives
//                              CLINT_soft_int. When undefined, msip reads 0,
//                              ignores writes, and CLINT_soft_int is tied to 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   CLINT_req_*         request: valid/ready handshake, we, addr, wdata, wmask
//   CLINT_resp_*        response: valid/ready handshake, rdata, err
//   CLINT_timer_int     machine timer interrupt level
//   CLINT_soft_int      machine software interrupt level
module ysyx_041461_clint #(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CLINT_req_valid,
  output logic        CLINT_req_ready,
  input  logic        CLINT_req_we,
  input  logic [63:0] CLINT_req_addr,
  input  logic [63:0] CLINT_req_wdata,
  input  logic [7:0]  CLINT_req_wmask,
  output logic        CLINT_resp_valid,
  input  logic        CLINT_resp_ready,
  output logic [63:0] CLINT_resp_rdata,
  output logic        CLINT_resp_err,
  output logic        CLINT_timer_int,
  output logic        CLINT_soft_int
);

  localparam logic [63:0] ADDR_MSIP     = BASE;
  localparam logic [63:0] ADDR_MTIMECMP = BASE + 64'h4000;
  localparam logic [63:0] ADDR_MTIME    = BASE + 64'hBFF8;
  localparam logic [15:0] TICK_LAST     = 16'(TICK_DIV - 1);

  // architectural state
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic [15:0] presc_q;
  logic        timer_int_q;
  logic        msip_val;

  // response channel
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  // decode
  logic        accept;
  logic        addr_aligned;
  logic        hit_msip;
  logic        hit_mtimecmp;
  logic        hit_mtime;
  logic        addr_err;
  logic        wr_any;
  logic        wr_mtime;
  logic        wr_mtimecmp;
  logic [63:0] byte_mask;
  logic [63:0] mtime_wr_val;
  logic [63:0] mtimecmp_wr_val;
  logic [63:0] rd_val;
  logic        tick;

  // A new request is taken whenever the response slot is free or is being
  // drained this same cycle, which allows one access per cycle.
  assign CLINT_req_ready = !resp_valid_q || CLINT_resp_ready;
  assign accept          = CLINT_req_valid && CLINT_req_ready && !rst;

  always_comb begin
    addr_aligned = (CLINT_req_addr[2:0] == 3'b000);
    hit_msip     = addr_aligned && (CLINT_req_addr == ADDR_MSIP);
    hit_mtimecmp = addr_aligned && (CLINT_req_addr == ADDR_MTIMECMP);
    hit_mtime    = addr_aligned && (CLINT_req_addr == ADDR_MTIME);
    addr_err     = !(hit_msip || hit_mtimecmp || hit_mtime);
  end

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 8; i++) begin
      byte_mask[i*8 +: 8] = {8{CLINT_req_wmask[i]}};
    end
  end

  // An all-zero wmask is treated as no write at all, so it neither restarts
  // the prescaler nor suppresses an mtime increment.
  assign wr_any      = accept && CLINT_req_we && (CLINT_req_wmask != 8'h00);
  assign wr_mtime    = wr_any && hit_mtime;
  assign wr_mtimecmp = wr_any && hit_mtimecmp;

  assign mtime_wr_val    = (mtime_q    & ~byte_mask) | (CLINT_req_wdata & byte_mask);
  assign mtimecmp_wr_val = (mtimecmp_q & ~byte_mask) | (CLINT_req_wdata & byte_mask);

  // Read data comes from the current register values, i.e. before any
  // increment or write that lands on the acceptance edge.
  always_comb begin
    rd_val = '0;
    if (hit_mtime) begin
      rd_val = mtime_q;
    end else if (hit_mtimecmp) begin
      rd_val = mtimecmp_q;
    end else if (hit_msip) begin
      rd_val = {63'b0, msip_val};
    end
  end

  assign tick = (presc_q == TICK_LAST);

  // mtime and prescaler; a software write wins over the tick and restarts
  // the prescaler so the next increment is a full TICK_DIV period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      presc_q <= '0;
    end else if (wr_mtime) begin
      mtime_q <= mtime_wr_val;
      presc_q <= '0;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_q <= '1;
    end else if (wr_mtimecmp) begin
      mtimecmp_q <= mtimecmp_wr_val;
    end
  end

  // Registered compare: follows the register values one cycle late, so it
  // stays high while the compare holds and drops only once a write (or an
  // mtime wrap) breaks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_int_q <= 1'b0;
    end else begin
      timer_int_q <= (mtime_q >= mtimecmp_q);
    end
  end

`ifdef YSYX_041461_CLINT_MSIP_EN
  logic msip_q;
  logic wr_msip;

  assign wr_msip = wr_any && hit_msip && CLINT_req_wmask[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else if (wr_msip) begin
      msip_q <= CLINT_req_wdata[0];
    end
  end

  assign msip_val = msip_q;
`else
  assign msip_val = 1'b0;
`endif

  // Response slot: loaded on acceptance, held until drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_rdata_q <= (CLINT_req_we || addr_err) ? 64'd0 : rd_val;
      resp_err_q   <= addr_err;
    end else if (CLINT_resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign CLINT_resp_valid = resp_valid_q;
  assign CLINT_resp_rdata = resp_rdata_q;
  assign CLINT_resp_err   = resp_err_q;
  assign CLINT_timer_int  = timer_int_q;
  assign CLINT_soft_int   = msip_val;

endmodule

// File: tb/tb_ysyx_041461_clint.sv
// Self-checking bench for ysyx_041461_clint. Two instances share all inputs:
// dut (TICK_DIV = 1) is checked against the scoreboard, dut4 (TICK_DIV = 4)
// is checked directly on the prescaler read.
module tb_ysyx_041461_clint;

  localparam logic [63:0] B        = 64'h0200_0000;
  localparam logic [63:0] A_MSIP   = B;
  localparam logic [63:0] A_CMP    = B + 64'h4000;
  localparam logic [63:0] A_MTIME  = B + 64'hBFF8;
`ifdef YSYX_041461_CLINT_MSIP_EN
  localparam logic MSIP_ON = 1'b1;
`else
  localparam logic MSIP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_ready = 1'b1;

  logic        req_ready, resp_valid, resp_err, timer_int, soft_int;
  logic [63:0] resp_rdata;
  logic        req_ready4, resp_valid4, resp_err4, timer_int4, soft_int4;
  logic [63:0] resp_rdata4;

  ysyx_041461_clint #(.BASE(B), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .CLINT_req_valid(req_valid), .CLINT_req_ready(req_ready),
    .CLINT_req_we(req_we), .CLINT_req_addr(req_addr),
    .CLINT_req_wdata(req_wdata), .CLINT_req_wmask(req_wmask),
    .CLINT_resp_valid(resp_valid), .CLINT_resp_ready(resp_ready),
    .CLINT_resp_rdata(resp_rdata), .CLINT_resp_err(resp_err),
    .CLINT_timer_int(timer_int), .CLINT_soft_int(soft_int)
  );

  ysyx_041461_clint #(.BASE(B), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .CLINT_req_valid(req_valid), .CLINT_req_ready(req_ready4),
    .CLINT_req_we(req_we), .CLINT_req_addr(req_addr),
    .CLINT_req_wdata(req_wdata), .CLINT_req_wmask(req_wmask),
    .CLINT_resp_valid(resp_valid4), .CLINT_resp_ready(resp_ready),
    .CLINT_resp_rdata(resp_rdata4), .CLINT_resp_err(resp_err4),
    .CLINT_timer_int(timer_int4), .CLINT_soft_int(soft_int4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // mtime model for dut: value mt_w was loaded on edge mt_n0
  logic [63:0] mt_w = '0;
  int          mt_n0 = 0;

  function automatic logic [63:0] mt_exp(input int n);
    return mt_w + 64'(n - 1 - mt_n0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] d, input logic err);
    exp_t e;
    e.tag = tag; e.rdata = d; e.err = err;
    sb.push_back(e);
  endtask

  task automatic send(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, output int n);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("req_ready_timeout", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    n = cyc;
    req_valid = 1'b0;
  endtask

  task automatic collect_now();
    exp_t e;
    chk("resp_valid", {63'b0, resp_valid}, 64'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
      chk({e.tag, "_err"}, {63'b0, resp_err}, {63'b0, e.err});
    end
  endtask

  task automatic collect();
    @(negedge clk);
    collect_now();
  endtask

  task automatic rd(input string tag, input logic [63:0] addr,
                    input logic [63:0] exp, input logic experr);
    int n;
    send(1'b0, addr, 64'd0, 8'h00, n);
    push(tag, exp, experr);
    collect();
  endtask

  task automatic rd_mtime(input string tag, output int n);
    send(1'b0, A_MTIME, 64'd0, 8'h00, n);
    push(tag, mt_exp(n), 1'b0);
    collect();
  endtask

  task automatic wr(input string tag, input logic [63:0] addr, input logic [63:0] d,
                    input logic [7:0] mask, input logic experr, output int n);
    send(1'b1, addr, d, mask, n);
    push(tag, 64'd0, experr);
    collect();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, nr, cnt;
    logic [63:0] r1;

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_timer_int", {63'b0, timer_int}, 64'd0);
    chk("rst_soft_int", {63'b0, soft_int}, 64'd0);
    rst = 1'b0;
    mt_w = '0; mt_n0 = cyc;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);

    rd("rst_cmp", A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (timer_int !== 1'b0) cnt++;
    end
    chk("rst_timer_low_100", 64'(cnt), 64'd0);

    // ---- prescaler ----
    wr("ps_wr_mtime", A_MTIME, 64'd0, 8'hFF, 1'b0, n0);
    mt_w = 64'd0; mt_n0 = n0;
    repeat (40) @(posedge clk);
    rd_mtime("ps_mtime_div1", nr);
    chk("ps_mtime_div4", resp_rdata4, 64'((nr - 1 - n0) / 4));
    chk("ps_mtime_div4_abs", resp_rdata4, 64'd10);
    chk("ps_div4_valid", {63'b0, resp_valid4}, 64'd1);
    chk("ps_div4_err", {63'b0, resp_err4}, 64'd0);
    chk("ps_div4_ready", {63'b0, req_ready4}, 64'd1);
    chk("ps_div4_timer", {63'b0, timer_int4}, 64'd0);
    chk("ps_div4_soft", {63'b0, soft_int4}, 64'd0);

    // ---- back-to-back reads, one response per cycle ----
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_MTIME; req_wmask = 8'h00;
    @(posedge clk); #1;
    push("b2b_first", mt_exp(cyc), 1'b0);
    @(negedge clk);
    r1 = resp_rdata;
    collect_now();
    @(posedge clk); #1;
    req_valid = 1'b0;
    push("b2b_second", mt_exp(cyc), 1'b0);
    collect();
    chk("b2b_delta", resp_rdata - r1, 64'd1);

    // ---- compare ----
    wr("cmp_mt0", A_MTIME, 64'd0, 8'hFF, 1'b0, n);
    mt_w = 64'd0; mt_n0 = n;
    wr("cmp_wr50", A_CMP, 64'd50, 8'hFF, 1'b0, n);
    wr("cmp_mt45", A_MTIME, 64'd45, 8'hFF, 1'b0, n0);
    mt_w = 64'd45; mt_n0 = n0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("cmp_rise_k%0d", k), {63'b0, timer_int}, {63'b0, (k >= 6)});
    end
    wr("cmp_wr1000", A_CMP, 64'd1000, 8'hFF, 1'b0, n);
    chk("cmp_timer_at_resp", {63'b0, timer_int}, 64'd1);
    @(negedge clk);
    chk("cmp_timer_cleared", {63'b0, timer_int}, 64'd0);

    // ---- byte mask and empty mask ----
    wr("bm_ones", A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, n);
    wr("bm_low", A_CMP, 64'h0000_0000_1234_5678, 8'h0F, 1'b0, n);
    rd("bm_read", A_CMP, 64'hFFFF_FFFF_1234_5678, 1'b0);
    wr("bm_nomask_cmp", A_CMP, 64'd0, 8'h00, 1'b0, n);
    rd("bm_nomask_cmp_rd", A_CMP, 64'hFFFF_FFFF_1234_5678, 1'b0);
    wr("bm_nomask_mt", A_MTIME, 64'd0, 8'h00, 1'b0, n);
    rd_mtime("bm_nomask_mt_rd", n);

    // ---- errors ----
    rd("err_4004", B + 64'h4004, 64'd0, 1'b1);
    rd("err_100", B + 64'h100, 64'd0, 1'b1);
    rd("err_c000", B + 64'hC000, 64'd0, 1'b1);
    wr("err_wr_cmp_mis", B + 64'h4001, 64'd0, 8'hFF, 1'b1, n);
    wr("err_wr_unmapped", B + 64'h8000, 64'd0, 8'hFF, 1'b1, n);
    wr("err_wr_mt_mis", B + 64'hBFFC, 64'd0, 8'hFF, 1'b1, n);
    rd("err_cmp_kept", A_CMP, 64'hFFFF_FFFF_1234_5678, 1'b0);
    rd_mtime("err_mt_kept", n);

    // ---- msip ----
    wr("msip_set", A_MSIP, 64'd1, 8'h01, 1'b0, n);
    chk("msip_soft_set", {63'b0, soft_int}, {63'b0, MSIP_ON});
    rd("msip_rd1", A_MSIP, {63'b0, MSIP_ON}, 1'b0);
    wr("msip_clr", A_MSIP, 64'd0, 8'h01, 1'b0, n);
    chk("msip_soft_clr", {63'b0, soft_int}, 64'd0);
    rd("msip_rd0", A_MSIP, 64'd0, 1'b0);

    // ---- mtime wrap ----
    wr("wrap_cmp", A_CMP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, n);
    wr("wrap_mt", A_MTIME, 64'hFFFF_FFFF_FFFF_FFFD, 8'hFF, 1'b0, n0);
    mt_w = 64'hFFFF_FFFF_FFFF_FFFD; mt_n0 = n0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_timer_k%0d", k), {63'b0, timer_int}, {63'b0, (k == 2 || k == 3)});
    end
    rd_mtime("wrap_mt_rd", n);

    // ---- backpressure ----
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMP; req_wmask = 8'h00;
    @(posedge clk); #1;
    push("bp_cmp", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    req_addr = A_MTIME;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), {63'b0, resp_valid}, 64'd1);
      chk($sformatf("bp_rdata_%0d", i), resp_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
      chk($sformatf("bp_req_ready_%0d", i), {63'b0, req_ready}, 64'd0);
    end
    collect_now();
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_release", {63'b0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    push("bp_next_mtime", mt_exp(cyc), 1'b0);
    collect();

    // ---- reset mid-transaction ----
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CMP; req_wmask = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_pending", {63'b0, resp_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dropped", {63'b0, resp_valid}, 64'd0);
    chk("midrst_timer", {63'b0, timer_int}, 64'd0);
    @(negedge clk);
    chk("midrst_ignored", {63'b0, resp_valid}, 64'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    mt_w = '0; mt_n0 = cyc;
    @(negedge clk);
    chk("postrst_idle", {63'b0, resp_valid}, 64'd0);
    rd("postrst_cmp", A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rd_mtime("postrst_mt", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
